// File: rtl/i2c_master_arbiter_pkg.sv
// Shared types for the I2C master arbiter: FSM states, default bus widths,
// and the single-byte command record.
package i2c_pkg;

  localparam int ADDR_WIDTH_DEF = 7;
  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2,
    RESP      = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic [ADDR_WIDTH_DEF-1:0] addr;
    logic [DATA_WIDTH_DEF-1:0] data;
    logic                      rw;
  } i2c_cmd_t;

endpackage

// File: rtl/i2c_master_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at rr_ptr,
// rr_ptr+1, ... wrapping at NUM_REQ by explicit compare.
module i2c_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDW-1:0]     i_rr_ptr,
  output logic               o_found,
  output logic [IDW-1:0]     o_winner
);

  always_comb begin
    o_found  = 1'b0;
    o_winner = '0;
    // Scan farthest-first so the candidate nearest rr_ptr is written last.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int            w_sum;
      logic [IDW-1:0] w_idx;
      w_sum = int'(i_rr_ptr) + k;
      if (w_sum >= NUM_REQ) w_sum = w_sum - NUM_REQ;
      w_idx = IDW'(w_sum);
      if (i_req[w_idx]) begin
        o_found  = 1'b1;
        o_winner = w_idx;
      end
    end
  end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Round-robin sharing of one I2C master between NUM_REQ requesters; each
// command is one byte, always closed with STOP, with a per-transaction timeout.
//   state     | meaning
//   IDLE      | waiting for a request while the master is ready
//   LAUNCH    | m_enable high until the master leaves its idle state
//   WAIT_DONE | m_enable low so the master stops; wait for ready again
//   RESP      | one-cycle rsp_valid to the owner, advance rr_ptr
module i2c_master_arbiter
  import i2c_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
  input  logic [NUM_REQ-1:0]             req_rw,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_WIDTH-1:0]          rsp_data,
  output logic                           rsp_timeout,
  output logic                           busy,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic [ADDR_WIDTH-1:0]          m_address,
  output logic [DATA_WIDTH-1:0]          m_data_in,
  output logic                           m_rw,
  output logic                           m_enable,
  input  logic [DATA_WIDTH-1:0]          m_data_out,
  input  logic                           m_ready
);

  localparam int IDW  = $clog2(NUM_REQ);
  localparam int CNTW = $clog2(TIMEOUT_CYCLES);

  arb_state_t            r_state, w_next;
  logic [IDW-1:0]        r_rr_ptr, r_grant_id;
  logic [CNTW-1:0]       r_cnt;
  logic                  r_to_flag;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data_in;
  logic                  r_rw;
  logic                  w_found;
  logic [IDW-1:0]        w_winner;
  logic                  w_grant;
  logic                  w_active;
  logic                  w_timeout;

  i2c_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_rr (
    .i_req    (req_valid),
    .i_rr_ptr (r_rr_ptr),
    .o_found  (w_found),
    .o_winner (w_winner)
  );

  // rst gate keeps req_ready low while reset is held with requests pending.
  assign w_grant   = (r_state == IDLE) && w_found && m_ready && !rst;
  assign w_active  = (r_state == LAUNCH) || (r_state == WAIT_DONE);
  assign w_timeout = w_active && (r_cnt == CNTW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (w_grant) w_next = LAUNCH;
      LAUNCH:    if (w_timeout) w_next = RESP;
                 else if (!m_ready) w_next = WAIT_DONE;
      WAIT_DONE: if (w_timeout || m_ready) w_next = RESP;
      RESP:      w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready   = '0;
    rsp_valid   = '0;
    rsp_timeout = 1'b0;
    m_enable    = 1'b0;
    busy        = (r_state != IDLE);
    case (r_state)
      IDLE:   if (w_grant) req_ready[w_winner] = 1'b1;
      LAUNCH: m_enable = !w_timeout;
      RESP: begin
        rsp_valid[r_grant_id] = 1'b1;
        rsp_timeout           = r_to_flag;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_cnt      <= '0;
      r_to_flag  <= 1'b0;
      r_rsp_data <= '0;
      r_addr     <= '0;
      r_data_in  <= '0;
      r_rw       <= 1'b0;
    end else begin
      if (w_grant) begin
        r_addr     <= req_addr[int'(w_winner)*ADDR_WIDTH +: ADDR_WIDTH];
        r_data_in  <= req_data[int'(w_winner)*DATA_WIDTH +: DATA_WIDTH];
        r_rw       <= req_rw[w_winner];
        r_grant_id <= w_winner;
        r_cnt      <= '0;
        r_to_flag  <= 1'b0;
      end
      if (w_active) begin
        if (w_timeout) begin
          r_to_flag  <= 1'b1;
          r_rsp_data <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
          if ((r_state == WAIT_DONE) && m_ready) r_rsp_data <= m_data_out;
        end
      end
      if (r_state == RESP) begin
        r_rr_ptr  <= (r_grant_id == IDW'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;
        r_to_flag <= 1'b0;
      end
    end
  end

  assign rsp_data  = r_rsp_data;
  assign grant_id  = r_grant_id;
  assign m_address = r_addr;
  assign m_data_in = r_data_in;
  assign m_rw      = r_rw;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Scoreboard bench for i2c_master_arbiter with a behavioural master+slave
// model (slave at 0x2A); expectations are queued at stimulus time.
module tb_i2c_master_arbiter;
  import i2c_pkg::*;

  localparam int NR = 4;
  localparam int AW = 7;
  localparam int DW = 8;
  localparam int TO = 64;
  localparam logic [AW-1:0] SLAVE_ADDR = 7'h2A;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [NR-1:0]   req_ready;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]   req_rw = '0;
  logic [NR-1:0]   rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            rsp_timeout;
  logic            busy;
  logic [1:0]      grant_id;
  logic [AW-1:0]   m_address;
  logic [DW-1:0]   m_data_in;
  logic            m_rw;
  logic            m_enable;
  logic [DW-1:0]   m_data_out;
  logic            m_ready;

  i2c_master_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_rw(req_rw),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
    .busy(busy), .grant_id(grant_id),
    .m_address(m_address), .m_data_in(m_data_in), .m_rw(m_rw),
    .m_enable(m_enable), .m_data_out(m_data_out), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural master + slave: 20 cycles for an addressed slave, 10 for a NACK.
  logic          stuck = 1'b0;
  logic [DW-1:0] slave_tx = 8'h3C;
  logic [DW-1:0] slave_rx = '0;
  int            stop_cnt = 0;
  int            chain_err = 0;
  logic          mbusy;
  int            mcnt;
  logic [AW-1:0] maddr;
  logic          mrw;
  logic [DW-1:0] mdin;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ready    <= 1'b1;
      m_data_out <= '0;
      mbusy      <= 1'b0;
      mcnt       <= 0;
    end else if (!mbusy) begin
      if (m_enable && m_ready && !stuck) begin
        mbusy   <= 1'b1;
        m_ready <= 1'b0;
        maddr   <= m_address;
        mrw     <= m_rw;
        mdin    <= m_data_in;
        mcnt    <= (m_address == SLAVE_ADDR) ? 20 : 10;
      end
    end else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
    end else begin
      mbusy   <= 1'b0;
      m_ready <= 1'b1;
      if (m_enable) chain_err <= chain_err + 1;
      else          stop_cnt  <= stop_cnt + 1;
      m_data_out <= (mrw && maddr == SLAVE_ADDR) ? slave_tx : '0;
      if (!mrw && maddr == SLAVE_ADDR) slave_rx <= mdin;
    end
  end

  typedef struct {
    int       id;
    i2c_cmd_t cmd;
  } grant_exp_t;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
    logic          to;
    int            lat;
  } rsp_exp_t;

  grant_exp_t gq[$];
  rsp_exp_t   rq[$];
  int         grant_cnt = 0;
  int         rsp_cnt = 0;
  int         grant_cyc = 0;
  logic       pend = 1'b0;
  i2c_cmd_t   pend_cmd;

  always @(negedge clk) begin
    grant_exp_t g;
    rsp_exp_t   r;
    if (pend) begin
      chk("cmd_addr", m_address, pend_cmd.addr);
      chk("cmd_data", m_data_in, pend_cmd.data);
      chk("cmd_rw", m_rw, pend_cmd.rw);
      pend = 1'b0;
    end
    if (req_ready != 0) begin
      if (gq.size() == 0) chk("grant_unexpected", req_ready, 0);
      else begin
        g = gq.pop_front();
        chk("grant_onehot", req_ready, 1 << g.id);
        pend      = 1'b1;
        pend_cmd  = g.cmd;
        grant_cyc = cyc;
      end
      grant_cnt++;
    end
    if (rsp_valid != 0) begin
      if (rq.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
      else begin
        r = rq.pop_front();
        chk("rsp_onehot", rsp_valid, 1 << r.id);
        chk("rsp_data", rsp_data, r.data);
        chk("rsp_timeout", rsp_timeout, r.to);
        chk("rsp_grant_id", grant_id, r.id);
        chk("rsp_m_enable", m_enable, 0);
        if (r.lat >= 0) chk("rsp_latency", cyc - grant_cyc, r.lat);
      end
      rsp_cnt++;
    end
  end

  task automatic expect_grant(int id, logic [AW-1:0] a, logic [DW-1:0] d, logic rw);
    grant_exp_t g;
    g.id = id;
    g.cmd.addr = a;
    g.cmd.data = d;
    g.cmd.rw = rw;
    gq.push_back(g);
  endtask

  task automatic expect_rsp(int id, logic [DW-1:0] d, logic to, int lat);
    rsp_exp_t r;
    r.id = id;
    r.data = d;
    r.to = to;
    r.lat = lat;
    rq.push_back(r);
  endtask

  task automatic set_req(int id, logic [AW-1:0] a, logic [DW-1:0] d, logic rw);
    req_addr[id*AW +: AW] = a;
    req_data[id*DW +: DW] = d;
    req_rw[id]            = rw;
    req_valid[id]         = 1'b1;
  endtask

  task automatic issue(int id, logic [AW-1:0] a, logic [DW-1:0] d, logic rw);
    bit got = 1'b0;
    @(posedge clk);
    #1 set_req(id, a, d, rw);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (req_ready[id]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("req_ready_wait", 0, 1);
    @(posedge clk);
    #1 req_valid[id] = 1'b0;
  endtask

  task automatic wait_rsp(int n);
    for (int i = 0; i < 1000; i++) begin
      if (rsp_cnt >= n) return;
      @(posedge clk);
    end
    chk("rsp_wait", rsp_cnt, n);
  endtask

  initial begin
    int base;
    bit done;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_m_enable", m_enable, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_rsp_data", rsp_data, 0);
    @(negedge clk) rst = 1'b0;

    // Single write, req0
    expect_grant(0, 7'h2A, 8'hA5, 1'b0);
    expect_rsp(0, 8'h00, 1'b0, -1);
    issue(0, 7'h2A, 8'hA5, 1'b0);
    wait_rsp(1);
    chk("write_slave_rx", slave_rx, 8'hA5);
    chk("write_stop", stop_cnt, 1);

    // Single read, req2
    expect_grant(2, 7'h2A, 8'h00, 1'b1);
    expect_rsp(2, 8'h3C, 1'b0, -1);
    issue(2, 7'h2A, 8'h00, 1'b1);
    wait_rsp(2);
    @(negedge clk);
    chk("read_grant_id", grant_id, 2);

    // Wrong address read, req3 (rsp_data drops from 0x3C to 0)
    expect_grant(3, 7'h11, 8'h00, 1'b1);
    expect_rsp(3, 8'h00, 1'b0, -1);
    issue(3, 7'h11, 8'h00, 1'b1);
    wait_rsp(3);

    // Fairness: rr_ptr back at 0, all four held valid for 8 grants
    for (int k = 0; k < 8; k++) begin
      expect_grant(k % 4, 7'h2A, 8'(8'h10 + k % 4), 1'b1);
      expect_rsp(k % 4, 8'h3C, 1'b0, -1);
    end
    base = grant_cnt;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) set_req(i, 7'h2A, 8'(8'h10 + i), 1'b1);
    done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      if (grant_cnt >= base + 8) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("fair_grants", grant_cnt - base, 8);
    #1 req_valid = '0;
    wait_rsp(11);

    // Timeout with a master that never leaves ready
    stuck = 1'b1;
    expect_grant(2, 7'h2A, 8'h00, 1'b1);
    expect_rsp(2, 8'h00, 1'b1, TO + 1);
    issue(2, 7'h2A, 8'h00, 1'b1);
    wait_rsp(12);
    stuck = 1'b0;

    // Read on req3 (rr_ptr is 3) leaves rsp_data non-zero before the reset test
    expect_grant(3, 7'h2A, 8'h00, 1'b1);
    expect_rsp(3, 8'h3C, 1'b0, -1);
    issue(3, 7'h2A, 8'h00, 1'b1);
    wait_rsp(13);

    // Reset mid-WAIT_DONE: lost transaction gets no response
    expect_grant(3, 7'h2A, 8'h00, 1'b1);
    issue(3, 7'h2A, 8'h00, 1'b1);
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy && !m_ready) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("reach_wait_done", 0, 1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_grant_id", grant_id, 0);
    chk("mid_rst_rsp_data", rsp_data, 0);
    chk("mid_rst_m_address", m_address, 0);
    chk("mid_rst_m_rw", m_rw, 0);
    chk("mid_rst_m_enable", m_enable, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    expect_grant(1, 7'h2A, 8'h77, 1'b0);
    expect_rsp(1, 8'h00, 1'b0, -1);
    issue(1, 7'h2A, 8'h77, 1'b0);
    wait_rsp(14);
    @(negedge clk);
    chk("post_rst_grant_id", grant_id, 1);
    chk("post_rst_slave_rx", slave_rx, 8'h77);

    repeat (5) @(posedge clk);
    chk("grant_q_empty", gq.size(), 0);
    chk("rsp_q_empty", rq.size(), 0);
    chk("no_chained_txn", chain_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
